// File: rtl/wb_ram_slave.sv
// wb_ram_slave: Wishbone classic slave RAM with byte lanes and programmable wait states; WB_RAM_ERR_EN adds out-of-range error termination
module wb_ram_slave #(
  parameter int ADR_W    = 12,
  parameter int DEPTH_W  = 8,
  parameter int WAIT_CYC = 2
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic [ADR_W-1:0] wb_adr_i,
  input  logic [31:0]      wb_dat_i,
  output logic [31:0]      wb_dat_o,
  input  logic             wb_we_i,
  input  logic [3:0]       wb_sel_i,
  input  logic             wb_stb_i,
  input  logic             wb_cyc_i,
  output logic             wb_ack_o
`ifdef WB_RAM_ERR_EN
  , output logic           wb_err_o
`endif
);
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;
  localparam logic [3:0] WAIT_LD = 4'(WAIT_CYC);
  state_t state, state_n;
  logic [3:0] cnt, cnt_n;
  logic req, fire, in_oor, err_q;
  logic we_q, oor_q, cur_we, cur_oor;
  logic [DEPTH_W-1:0] idx_q, cur_idx;
  logic [3:0] sel_q, cur_sel;
  logic [31:0] dat_q, cur_dat;
  logic [31:0] mem [2**DEPTH_W];
  assign req = wb_cyc_i & wb_stb_i;
`ifdef WB_RAM_ERR_EN
  assign in_oor = |wb_adr_i[ADR_W-1:DEPTH_W+2];
  assign wb_err_o = err_q;
  logic unused_adr;
  assign unused_adr = &wb_adr_i[1:0];
`else
  assign in_oor = 1'b0;
  logic unused_adr;
  assign unused_adr = &{wb_adr_i[ADR_W-1:DEPTH_W+2], wb_adr_i[1:0], err_q};
`endif
  // In IDLE the request fields come straight from the bus so a zero-wait transfer completes on its first edge
  always_comb begin
    cur_idx = state == S_IDLE ? wb_adr_i[DEPTH_W+1:2] : idx_q;
    cur_we  = state == S_IDLE ? wb_we_i : we_q;
    cur_sel = state == S_IDLE ? wb_sel_i : sel_q;
    cur_dat = state == S_IDLE ? wb_dat_i : dat_q;
    cur_oor = state == S_IDLE ? in_oor : oor_q;
  end
  // Next-state logic; fire marks the edge that enters ACK and terminates the transfer
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    fire    = 1'b0;
    case (state)
      S_IDLE: if (req) begin
        cnt_n   = WAIT_LD;
        state_n = WAIT_LD == 4'd0 ? S_ACK : S_WAIT;
        fire    = WAIT_LD == 4'd0;
      end
      S_WAIT: begin
        cnt_n   = cnt - 4'd1;
        state_n = !req ? S_IDLE : cnt == 4'd1 ? S_ACK : S_WAIT;
        fire    = req && cnt == 4'd1;
      end
      default: state_n = S_IDLE;
    endcase
  end
  // State, latched request, registered terminations and read data
  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      state    <= S_IDLE;
      cnt      <= 4'd0;
      wb_ack_o <= 1'b0;
      err_q    <= 1'b0;
      wb_dat_o <= 32'd0;
      idx_q    <= '0;
      we_q     <= 1'b0;
      sel_q    <= 4'd0;
      dat_q    <= 32'd0;
      oor_q    <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      wb_ack_o <= fire & ~cur_oor;
      err_q    <= fire & cur_oor;
      if (state == S_IDLE && req) begin
        idx_q <= wb_adr_i[DEPTH_W+1:2];
        we_q  <= wb_we_i;
        sel_q <= wb_sel_i;
        dat_q <= wb_dat_i;
        oor_q <= in_oor;
      end
      if (fire && !cur_we && !cur_oor) wb_dat_o <= mem[cur_idx];
    end
  end
  // Byte-lane RAM write; gated by reset so a held reset can never commit a write
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i && fire && cur_we && !cur_oor)
      for (int i = 0; i < 4; i++)
        if (cur_sel[i]) mem[cur_idx][8*i +: 8] <= cur_dat[8*i +: 8];
  end
endmodule

// File: tb/tb_wb_ram_slave.sv
// tb_wb_ram_slave: directed bench for wb_ram_slave (WAIT_CYC=2 and WAIT_CYC=0 instances)
module tb_wb_ram_slave;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [11:0] adr = '0;
  logic [31:0] dat_i = '0;
  logic we = 1'b0;
  logic [3:0] sel = '0;
  logic cyc0 = 1'b0, stb0 = 1'b0, cyc1 = 1'b0, stb1 = 1'b0;
  logic [31:0] dat_o0, dat_o1;
  logic ack0, ack1, err0;
  int checks = 0;
  int failures = 0;
  always #5 clk = ~clk;
  wb_ram_slave #(.ADR_W(12), .DEPTH_W(8), .WAIT_CYC(2)) dut0 (
    .wb_clk_i(clk), .wb_rst_i(rst_n), .wb_adr_i(adr), .wb_dat_i(dat_i), .wb_dat_o(dat_o0),
    .wb_we_i(we), .wb_sel_i(sel), .wb_stb_i(stb0), .wb_cyc_i(cyc0), .wb_ack_o(ack0)
`ifdef WB_RAM_ERR_EN
    , .wb_err_o(err0)
`endif
  );
`ifndef WB_RAM_ERR_EN
  assign err0 = 1'b0;
`endif
`ifdef WB_RAM_ERR_EN
  logic err1;
`endif
  wb_ram_slave #(.ADR_W(12), .DEPTH_W(8), .WAIT_CYC(0)) dut1 (
    .wb_clk_i(clk), .wb_rst_i(rst_n), .wb_adr_i(adr), .wb_dat_i(dat_i), .wb_dat_o(dat_o1),
    .wb_we_i(we), .wb_sel_i(sel), .wb_stb_i(stb1), .wb_cyc_i(cyc1), .wb_ack_o(ack1)
`ifdef WB_RAM_ERR_EN
    , .wb_err_o(err1)
`endif
  );
  task automatic xfer0(input logic w, input logic [11:0] a, input logic [31:0] d, input logic [3:0] s,
                       output int lat, output logic e);
    @(negedge clk);
    we = w; adr = a; dat_i = d; sel = s; cyc0 = 1'b1; stb0 = 1'b1;
    lat = 99; e = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (ack0 || err0) begin
        lat = i; e = err0;
        break;
      end
    end
    @(negedge clk);
    cyc0 = 1'b0; stb0 = 1'b0;
  endtask
  task automatic test_reset();
    #1;
    checks += 3;
    if (ack0 !== 1'b0) begin failures++; $display("FAIL reset_ack0 got=%b exp=0", ack0); end
    if (dat_o0 !== 32'd0) begin failures++; $display("FAIL reset_dat0 got=%h exp=0", dat_o0); end
    if (ack1 !== 1'b0) begin failures++; $display("FAIL reset_ack1 got=%b exp=0", ack1); end
`ifdef WB_RAM_ERR_EN
    checks++;
    if (err0 !== 1'b0) begin failures++; $display("FAIL reset_err0 got=%b exp=0", err0); end
`endif
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask
  task automatic test_write_read();
    int lat; logic e;
    xfer0(1'b1, 12'h010, 32'hDEADBEEF, 4'hF, lat, e);
    checks++;
    if (lat != 3) begin failures++; $display("FAIL write_latency got=%0d exp=3", lat); end
    @(posedge clk); #1;
    checks++;
    if (ack0 !== 1'b0) begin failures++; $display("FAIL ack_one_cycle got=%b exp=0", ack0); end
    xfer0(1'b0, 12'h010, 32'h0, 4'hF, lat, e);
    checks += 2;
    if (lat != 3) begin failures++; $display("FAIL read_latency got=%0d exp=3", lat); end
    if (dat_o0 !== 32'hDEADBEEF) begin failures++; $display("FAIL read_data got=%h exp=deadbeef", dat_o0); end
  endtask
  task automatic test_byte_lanes();
    int lat; logic e;
    xfer0(1'b1, 12'h010, 32'h11223344, 4'b0101, lat, e);
    xfer0(1'b0, 12'h010, 32'h0, 4'hF, lat, e);
    checks++;
    if (dat_o0 !== 32'hDE22BE44) begin failures++; $display("FAIL sel_0101 got=%h exp=de22be44", dat_o0); end
    xfer0(1'b1, 12'h010, 32'h00000000, 4'h0, lat, e);
    checks++;
    if (lat != 3) begin failures++; $display("FAIL sel0_ack got_lat=%0d exp=3", lat); end
    xfer0(1'b0, 12'h010, 32'h0, 4'hF, lat, e);
    checks++;
    if (dat_o0 !== 32'hDE22BE44) begin failures++; $display("FAIL sel0_nochange got=%h exp=de22be44", dat_o0); end
  endtask
  task automatic test_back_to_back();
    @(negedge clk);
    we = 1'b1; adr = 12'h004; dat_i = 32'hA5A55A5A; sel = 4'hF; cyc1 = 1'b1; stb1 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      checks++;
      if (ack1 !== ((i % 2) == 0)) begin failures++; $display("FAIL b2b_ack[%0d] got=%b exp=%b", i, ack1, (i % 2) == 0); end
    end
    @(negedge clk);
    cyc1 = 1'b0; stb1 = 1'b0;
    @(negedge clk);
    we = 1'b0; cyc1 = 1'b1; stb1 = 1'b1;
    @(posedge clk); #1;
    checks += 2;
    if (ack1 !== 1'b1) begin failures++; $display("FAIL zw_read_ack got=%b exp=1", ack1); end
    if (dat_o1 !== 32'hA5A55A5A) begin failures++; $display("FAIL zw_read_data got=%h exp=a5a55a5a", dat_o1); end
    @(negedge clk);
    cyc1 = 1'b0; stb1 = 1'b0;
  endtask
  task automatic test_abort();
    int lat; logic e;
    xfer0(1'b1, 12'h020, 32'hCAFEF00D, 4'hF, lat, e);
    @(negedge clk);
    we = 1'b1; adr = 12'h020; dat_i = 32'h12345678; sel = 4'hF; cyc0 = 1'b1; stb0 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cyc0 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      checks++;
      if (ack0 !== 1'b0) begin failures++; $display("FAIL abort_ack[%0d] got=%b exp=0", i, ack0); end
    end
    @(negedge clk);
    stb0 = 1'b0;
    xfer0(1'b0, 12'h020, 32'h0, 4'hF, lat, e);
    checks++;
    if (dat_o0 !== 32'hCAFEF00D) begin failures++; $display("FAIL abort_data got=%h exp=cafef00d", dat_o0); end
  endtask
  task automatic test_reset_mid();
    int lat; logic e;
    xfer0(1'b0, 12'h010, 32'h0, 4'hF, lat, e);
    @(negedge clk);
    we = 1'b1; adr = 12'h010; dat_i = 32'hFFFFFFFF; sel = 4'hF; cyc0 = 1'b1; stb0 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks += 2;
    if (ack0 !== 1'b0) begin failures++; $display("FAIL rst_mid_ack got=%b exp=0", ack0); end
    if (dat_o0 !== 32'd0) begin failures++; $display("FAIL rst_mid_dat got=%h exp=0", dat_o0); end
    @(posedge clk); #1;
    checks++;
    if (ack0 !== 1'b0) begin failures++; $display("FAIL rst_hold_ack got=%b exp=0", ack0); end
    @(negedge clk);
    cyc0 = 1'b0; stb0 = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    xfer0(1'b0, 12'h010, 32'h0, 4'hF, lat, e);
    checks++;
    if (dat_o0 !== 32'hDE22BE44) begin failures++; $display("FAIL rst_keep_ram got=%h exp=de22be44", dat_o0); end
`ifndef WB_RAM_ERR_EN
    xfer0(1'b0, 12'h410, 32'h0, 4'hF, lat, e);
    checks += 2;
    if (lat != 3) begin failures++; $display("FAIL alias_latency got=%0d exp=3", lat); end
    if (dat_o0 !== 32'hDE22BE44) begin failures++; $display("FAIL alias_data got=%h exp=de22be44", dat_o0); end
`endif
  endtask
`ifdef WB_RAM_ERR_EN
  task automatic test_err();
    int lat; logic e;
    xfer0(1'b1, 12'h000, 32'h0BADF00D, 4'hF, lat, e);
    xfer0(1'b0, 12'h000, 32'h0, 4'hF, lat, e);
    xfer0(1'b0, 12'h800, 32'h0, 4'hF, lat, e);
    checks += 4;
    if (lat != 3) begin failures++; $display("FAIL err_rd_latency got=%0d exp=3", lat); end
    if (e !== 1'b1) begin failures++; $display("FAIL err_rd_flag got=%b exp=1", e); end
    if (ack0 !== 1'b0) begin failures++; $display("FAIL err_rd_noack got=%b exp=0", ack0); end
    if (dat_o0 !== 32'h0BADF00D) begin failures++; $display("FAIL err_rd_dat got=%h exp=0badf00d", dat_o0); end
    xfer0(1'b1, 12'hC00, 32'hFFFFFFFF, 4'hF, lat, e);
    checks++;
    if (e !== 1'b1) begin failures++; $display("FAIL err_wr_flag got=%b exp=1", e); end
    xfer0(1'b0, 12'h000, 32'h0, 4'hF, lat, e);
    checks += 2;
    if (e !== 1'b0) begin failures++; $display("FAIL err_in_range got=%b exp=0", e); end
    if (dat_o0 !== 32'h0BADF00D) begin failures++; $display("FAIL err_wr_noram got=%h exp=0badf00d", dat_o0); end
  endtask
`endif
  initial begin
    test_reset();
    test_write_read();
    test_byte_lanes();
    test_back_to_back();
    test_abort();
    test_reset_mid();
`ifdef WB_RAM_ERR_EN
    test_err();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
endmodule
